// File: rtl/pbit_pkg.sv
// Shared definitions for the p-bit sampler: default widths, the tanh full-scale
// constant and the elaboration-time tanh table generator.
package pbit_pkg;

  localparam int IN_W_DEF       = 8;
  localparam int FRAC_DEF       = 4;
  localparam int RNG_W_DEF      = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int FULL_SCALE_DEF = (1 << (RNG_W_DEF - 1)) - 1;

  // Largest positive value of a signed word of the given width.
  function automatic int full_scale(input int rng_w);
    return (1 << (rng_w - 1)) - 1;
  endfunction

  // exp(-t) for t >= 0: halve the argument until it is small, evaluate a
  // Taylor series, then square back up. Only used at elaboration time.
  function automatic real exp_neg(input real t);
    real y;
    real term;
    real sum;
    int  k;
    y = t;
    k = 0;
    while (y > 0.5) begin
      y = y / 2.0;
      k = k + 1;
    end
    sum  = 1.0;
    term = 1.0;
    for (int n = 1; n <= 20; n++) begin
      term = -term * y / real'(n);
      sum  = sum + term;
    end
    for (int i = 0; i < k; i++) begin
      sum = sum * sum;
    end
    return sum;
  endfunction

  // Table entry for a signed field code: round_half_away(FS * tanh(code / 2^frac)).
  // Evaluated on the magnitude so the table is exactly odd-symmetric.
  function automatic int tanh_entry(input int code, input int frac, input int rng_w);
    int  mag;
    int  fs;
    int  m;
    real xr;
    real e;
    real th;
    mag = (code < 0) ? -code : code;
    fs  = full_scale(rng_w);
    xr  = real'(mag);
    for (int i = 0; i < frac; i++) begin
      xr = xr / 2.0;
    end
    e  = exp_neg(2.0 * xr);
    th = (1.0 - e) / (1.0 + e);
    // real-to-int conversion rounds to nearest with ties away from zero
    m  = int'(th * real'(fs));
    if (m > fs) m = fs;
    return (code < 0) ? -m : m;
  endfunction

endpackage

// File: rtl/pbit_tanh_lut.sv
// Registered tanh ROM forming the second pipeline stage. The address is the
// saturated field code (two's complement bits); the table is filled at
// elaboration from pbit_pkg::tanh_entry. The read register advances with en.
module pbit_tanh_lut
  import pbit_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int RNG_W = RNG_W_DEF
) (
  input  logic             clk,
  input  logic             en,
  input  logic [IN_W-1:0]  addr,
  output logic [RNG_W-1:0] th
);

  localparam int DEPTH = 1 << IN_W;

  logic [RNG_W-1:0] rom [DEPTH];

  // One constant per address; the upper half of the address space holds the
  // negative field codes.
  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam int CODE = (a >= (DEPTH / 2)) ? (a - DEPTH) : a;
    localparam int TH   = tanh_entry(CODE, FRAC, RNG_W);
    assign rom[a] = RNG_W'(TH);
  end

  // Synchronous read, held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en) th <= rom[addr];
  end

endmodule

// File: rtl/pbit_sampler.sv
// Stochastic p-bit: spin = sgn(tanh(I) - r) through a 3-stage pipeline
// (saturate, tanh LUT, compare), with an optional window accumulator counting
// +1 spins. Define PBIT_STATS_EN to build the accumulator; without it
// ones_count and window_done are tied to zero and window_len is ignored.
//
// Handshake: a beat moves on the input when in_valid & in_ready and on the
// output when out_valid & out_ready. Every stage moves together on
// adv = !v3 | out_ready, in_ready = adv, out_valid = v3; bubbles are never
// collapsed, so latency is exactly 3 clocks and throughput is one per clock.
module pbit_sampler
  import pbit_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int RNG_W = RNG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  field_in,
  input  logic [RNG_W-1:0] rng_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spin_out,
  input  logic [CNT_W-1:0] window_len,
  output logic [CNT_W-1:0] ones_count,
  output logic             window_done
);

  localparam logic [IN_W-1:0] MOST_NEG  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] NEG_LIMIT = {1'b1, {(IN_W-2){1'b0}}, 1'b1};

  logic             adv;
  logic             v1, v2, v3;
  logic [IN_W-1:0]  x_sat;
  logic [IN_W-1:0]  x1;
  logic [RNG_W-1:0] r1, r2;
  logic [RNG_W-1:0] th2;
  logic             spin;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign spin_out  = spin;

  // Fold the most negative code onto its mirror so the range is symmetric.
  always_comb begin
    x_sat = field_in;
    if (field_in == MOST_NEG) x_sat = NEG_LIMIT;
  end

  // Stage valids advance together; a reset drops every in-flight sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // S1 data: saturated field with its random word; no reset needed.
  always_ff @(posedge clk) begin
    if (adv) begin
      x1 <= x_sat;
      r1 <= rng_in;
    end
  end

  // S2: the LUT register holds th; the random word rides alongside it.
  pbit_tanh_lut #(
    .IN_W  (IN_W),
    .FRAC  (FRAC),
    .RNG_W (RNG_W)
  ) u_lut (
    .clk  (clk),
    .en   (adv),
    .addr (x1),
    .th   (th2)
  );

  // Random word aligned with the LUT output.
  always_ff @(posedge clk) begin
    if (adv) r2 <= r1;
  end

  // S3: signed compare; a tie yields -1. The spin only changes when a real
  // sample moves in, so it holds through stalls and bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spin <= 1'b0;
    end else if (adv && v2) begin
      spin <= ($signed(th2) > $signed(r2));
    end
  end

`ifdef PBIT_STATS_EN
  logic             xfer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cur_len;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] ones_inc;

  assign xfer = v3 && out_ready;

  // Window length is taken from the port only at the start of a window;
  // a zero length behaves as one.
  always_comb begin
    cur_len  = len_q;
    if (cnt == '0) begin
      cur_len = (window_len == '0) ? CNT_W'(1) : window_len;
    end
    cnt_inc  = cnt + CNT_W'(1);
    ones_inc = ones + CNT_W'(spin);
  end

  // Count transfers and +1 spins; publish and clear at the window boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      ones        <= '0;
      len_q       <= '0;
      ones_count  <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (xfer) begin
        if (cnt_inc == cur_len) begin
          ones_count  <= ones_inc;
          window_done <= 1'b1;
          cnt         <= '0;
          ones        <= '0;
        end else begin
          cnt   <= cnt_inc;
          ones  <= ones_inc;
          len_q <= cur_len;
        end
      end
    end
  end
`else
  logic unused_window_len;

  assign unused_window_len = ^window_len;
  assign ones_count        = '0;
  assign window_done       = 1'b0;
`endif

endmodule

// File: tb/tb_pbit_sampler.sv
// Directed bench for pbit_sampler (IN_W=8, FRAC=4, RNG_W=8, CNT_W=16).
// Inputs change on the falling edge; outputs are observed 1 time unit later,
// i.e. the state left by the previous rising edge.
module tb_pbit_sampler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  field_in;
  logic [7:0]  rng_in;
  logic        out_valid;
  logic        out_ready;
  logic        spin_out;
  logic [15:0] window_len;
  logic [15:0] ones_count;
  logic        window_done;

  int checks = 0;
  int passes = 0;

  logic        o_valid;
  logic        o_spin;
  logic        o_in_ready;
  logic        o_done;
  logic [15:0] o_ones;

  logic exp_q[$];

  pbit_sampler #(
    .IN_W  (8),
    .FRAC  (4),
    .RNG_W (8),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .field_in    (field_in),
    .rng_in      (rng_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .spin_out    (spin_out),
    .window_len  (window_len),
    .ones_count  (ones_count),
    .window_done (window_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one cycle of stimulus, then a snapshot of the outputs
  task automatic tick(input logic rst, input logic iv, input logic [7:0] f,
                      input logic [7:0] r, input logic ordy);
    @(negedge clk);
    rst_n     = rst;
    in_valid  = iv;
    field_in  = f;
    rng_in    = r;
    out_ready = ordy;
    #1;
    o_valid    = out_valid;
    o_spin     = spin_out;
    o_in_ready = in_ready;
    o_done     = window_done;
    o_ones     = ones_count;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", o_valid);
    else passes++;
    checks++;
    if (o_spin !== 1'b0) $display("FAIL reset_spin got %b exp 0", o_spin);
    else passes++;
    checks++;
    if (o_ones !== 16'd0) $display("FAIL reset_ones got %0d exp 0", o_ones);
    else passes++;
    checks++;
    if (o_done !== 1'b0) $display("FAIL reset_done got %b exp 0", o_done);
    else passes++;
    checks++;
    if (o_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", o_in_ready);
    else passes++;
  endtask

  // field 0 with rng 0 (tie -> 0) then rng -1 (-> 1); outputs at cycles 3 and 4
  task automatic test_latency();
    logic exp_v[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_s[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      if (t == 0)      tick(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
      else if (t == 1) tick(1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
      else             tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      checks++;
      if (o_valid !== exp_v[t]) $display("FAIL lat_valid t=%0d got %b exp %b", t, o_valid, exp_v[t]);
      else passes++;
      if (exp_v[t]) begin
        checks++;
        if (o_spin !== exp_s[t]) $display("FAIL lat_spin t=%0d got %b exp %b", t, o_spin, exp_s[t]);
        else passes++;
      end
    end
  endtask

  // -128 saturates to -127 (th=-127); +127 gives th=127
  task automatic test_saturation();
    logic [7:0] f[4] = '{8'h80, 8'h80, 8'h7F, 8'h7F};
    logic [7:0] r[4] = '{8'h80, 8'h81, 8'h7F, 8'h7E};
    logic       e[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 7; t++) begin
      if (t < 4) tick(1'b1, 1'b1, f[t], r[t], 1'b1);
      else       tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      if (t >= 3) begin
        checks++;
        if (o_valid !== 1'b1 || o_spin !== e[t-3])
          $display("FAIL sat_spin n=%0d got v=%b s=%b exp v=1 s=%b", t - 3, o_valid, o_spin, e[t-3]);
        else passes++;
      end
    end
  endtask

  // field +-16 -> th = +-97
  task automatic test_symmetry();
    logic [7:0] f[5] = '{8'h10, 8'h10, 8'hF0, 8'hF0, 8'hF0};
    logic [7:0] r[5] = '{8'd96, 8'd97, 8'h9E, 8'h9F, 8'hA0};
    logic       e[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 8; t++) begin
      if (t < 5) tick(1'b1, 1'b1, f[t], r[t], 1'b1);
      else       tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      if (t >= 3) begin
        checks++;
        if (o_valid !== 1'b1 || o_spin !== e[t-3])
          $display("FAIL sym_spin n=%0d got v=%b s=%b exp v=1 s=%b", t - 3, o_valid, o_spin, e[t-3]);
        else passes++;
      end
    end
  endtask

  // out_ready low for 5 cycles while in_valid stays high
  task automatic test_backpressure();
    logic [7:0] f[6] = '{8'h10, 8'hF0, 8'h7F, 8'h81, 8'h00, 8'h10};
    logic [7:0] r[6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'd97};
    logic       e[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   k      = 0;
    int   n_out  = 0;
    logic ordy;
    logic prev_stall = 1'b0;
    logic prev_spin  = 1'b0;
    logic want;
    exp_q.delete();
    for (int t = 0; t < 40 && n_out < 6; t++) begin
      ordy = !(t >= 3 && t <= 7);
      if (k < 6) tick(1'b1, 1'b1, f[k], r[k], ordy);
      else       tick(1'b1, 1'b0, 8'h00, 8'h00, ordy);
      if (o_valid && !ordy) begin
        checks++;
        if (o_in_ready !== 1'b0) $display("FAIL bp_in_ready t=%0d got %b exp 0", t, o_in_ready);
        else passes++;
        if (prev_stall) begin
          checks++;
          if (o_spin !== prev_spin) $display("FAIL bp_hold t=%0d got %b exp %b", t, o_spin, prev_spin);
          else passes++;
        end
      end
      prev_stall = o_valid && !ordy;
      prev_spin  = o_spin;
      if (o_valid && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL bp_extra t=%0d got spin %b exp none", t, o_spin);
        end else begin
          want = exp_q.pop_front();
          if (o_spin !== want) $display("FAIL bp_spin n=%0d got %b exp %b", n_out, o_spin, want);
          else passes++;
        end
        n_out++;
      end
      if (k < 6 && o_in_ready) begin
        exp_q.push_back(e[k]);
        k++;
      end
    end
    checks++;
    if (n_out != 6 || exp_q.size() != 0)
      $display("FAIL bp_count got %0d outputs exp 6 (pending %0d)", n_out, exp_q.size());
    else passes++;
    tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

`ifdef PBIT_STATS_EN
  task automatic test_window();
    logic [7:0] f3[3] = '{8'h7F, 8'h81, 8'h7F};
    logic [15:0] ones3[3] = '{16'd1, 16'd0, 16'd1};
    logic want_done;
    test_reset();
    window_len = 16'd4;
    for (int t = 0; t < 13; t++) begin
      if (t < 4)      tick(1'b1, 1'b1, 8'h7F, 8'h00, 1'b1);
      else if (t < 8) tick(1'b1, 1'b1, 8'h81, 8'h00, 1'b1);
      else            tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      if (t >= 3) begin
        want_done = (t == 7 || t == 11);
        checks++;
        if (o_done !== want_done) $display("FAIL win4_done t=%0d got %b exp %b", t, o_done, want_done);
        else passes++;
        if (t == 7) begin
          checks++;
          if (o_ones !== 16'd4) $display("FAIL win4_ones1 got %0d exp 4", o_ones);
          else passes++;
        end
        if (t == 11) begin
          checks++;
          if (o_ones !== 16'd0) $display("FAIL win4_ones2 got %0d exp 0", o_ones);
          else passes++;
        end
      end
    end
    window_len = 16'd0;
    for (int t = 0; t < 7; t++) begin
      if (t < 3) tick(1'b1, 1'b1, f3[t], 8'h00, 1'b1);
      else       tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      if (t >= 3) begin
        want_done = (t >= 4);
        checks++;
        if (o_done !== want_done) $display("FAIL win0_done t=%0d got %b exp %b", t, o_done, want_done);
        else passes++;
        if (t >= 4) begin
          checks++;
          if (o_ones !== ones3[t-4]) $display("FAIL win0_ones t=%0d got %0d exp %0d", t, o_ones, ones3[t-4]);
          else passes++;
        end
      end
    end
  endtask
`else
  task automatic test_window();
    window_len = 16'd1;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) tick(1'b1, 1'b1, 8'h7F, 8'h00, 1'b1);
      else       tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      if (t >= 3) begin
        checks++;
        if (o_done !== 1'b0 || o_ones !== 16'd0)
          $display("FAIL nostats t=%0d got done=%b ones=%0d exp 0/0", t, o_done, o_ones);
        else passes++;
      end
    end
  endtask
`endif

  // reset with three samples in flight, then one fresh sample
  task automatic test_reset_midflight();
    logic exp_v[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tick(1'b1, 1'b1, 8'h10, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'hF0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'h7F, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'h81, 8'h80, 1'b1);
    checks++;
    if (o_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", o_valid);
    else passes++;
    checks++;
    if (o_ones !== 16'd0) $display("FAIL rst_mid_ones got %0d exp 0", o_ones);
    else passes++;
    checks++;
    if (o_in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b exp 1", o_in_ready);
    else passes++;
    for (int t = 5; t < 9; t++) begin
      tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      checks++;
      if (o_valid !== exp_v[t-5]) $display("FAIL rst_mid_lat t=%0d got %b exp %b", t, o_valid, exp_v[t-5]);
      else passes++;
      if (t == 7) begin
        checks++;
        if (o_spin !== 1'b1) $display("FAIL rst_mid_spin got %b exp 1", o_spin);
        else passes++;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    field_in   = 8'h00;
    rng_in     = 8'h00;
    out_ready  = 1'b1;
    window_len = 16'd0;
    test_reset();
    test_latency();
    test_saturation();
    test_symmetry();
    test_backpressure();
    test_window();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pbit_sampler.md
Name: pbit_sampler

Overview:
- Downstream consumer of the LFSR random stream. Turns a signed local-field value and one LFSR word into a stochastic binary spin, m = sgn(tanh(I) − r).
- 3-stage valid/ready pipeline: saturate, tanh LUT, compare.
- Optional window accumulator counts +1 spins for magnetisation readout.
- One instance per p-bit. Sits between the synapse/field-sum logic and the spin-state register file.

Parameters:
- IN_W, 8, width of signed field input, two's complement fixed point.
- FRAC, 4, fractional bits of field_in (Q(IN_W−FRAC).FRAC).
- RNG_W, 8, width of rng_in. Connects directly to the LFSR output bus and is interpreted as signed.
- CNT_W, 16, width of window length and ones counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_valid  in  1  field_in/rng_in valid
- in_ready  out  1  pipeline can accept
- field_in  in  IN_W  signed local field I
- rng_in  in  RNG_W  LFSR word, treated as signed r
- out_valid  out  1  spin_out valid
- out_ready  in  1  consumer accepts spin
- spin_out  out  1  1 = +1, 0 = −1
- window_len  in  CNT_W  samples per statistics window
- ones_count  out  CNT_W  +1 count of last completed window
- window_done  out  1  one-cycle pulse when ones_count updates

Behaviour:
- Reset (rst_n=0 at posedge): all stage valids=0, spin_out=0, out_valid=0, ones_count=0, window_done=0, internal counters=0. Data registers may be left unreset.
- Pipeline advance: adv = !v3 | out_ready. in_ready = adv (combinational). The whole pipeline stalls when !adv; no bubbles are collapsed.
- Transfer rules:
  - Input transfers when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - out_valid = v3.
- Latency: exactly 3 clk from input transfer to out_valid with no stall. Throughput is 1/clk.
- S1 (saturate):
  - x = field_in, except −2^(IN_W−1) maps to −(2^(IN_W−1)−1), which makes the range symmetric.
  - rng_in is captured alongside x and travels with it.
- S2 (tanh):
  - th = round_half_away((2^(RNG_W−1)−1) · tanh(x / 2^FRAC)), signed RNG_W.
  - LUT contents are exact per this formula. LUT is odd-symmetric: th(−x) = −th(x), th(0) = 0.
- S3 (compare): spin = (th > r), signed compare. A tie gives 0 (−1).
- Stall hold: spin_out holds its value while out_valid & !out_ready.
- Window accumulator (per output transfer):
  - cnt += 1; ones += spin_out.
  - When cnt reaches L (L = window_len, with 0 treated as 1):
    - ones_count ← final ones, including the current sample.
    - window_done = 1 for one cycle.
    - cnt and ones clear the same cycle.
  - window_len is sampled when cnt = 0. Changes mid-window are ignored.
  - Counters never wrap within a window because L ≤ 2^CNT_W − 1.
- Reset mid-operation: in-flight samples are discarded and the partial window is lost.

Optional Feature:
- PBIT_STATS_EN
  - Defined: window accumulator present as above.
  - Undefined: no counters are synthesised; ones_count = 0, window_done = 0 constant; window_len is ignored.
  - Pipeline behaviour is identical in both builds.

Decomposition:
- Package pbit_pkg holds:
  - defaults for IN_W, FRAC, RNG_W;
  - a localparam for full-scale (2^(RNG_W−1)−1);
  - a constant function computing the tanh LUT entry, used for elaboration-time ROM init.
- Sub-module pbit_tanh_lut: registered ROM, 2^IN_W entries, address = x, one-cycle read. It forms S2 and takes an enable from adv.

Test Plan (IN_W=8, FRAC=4, RNG_W=8):
- Latency/throughput:
  - Stimulus: field=0, rng=0 at cycle 0, then field=0, rng=−1 (0xFF) at cycle 1, out_ready=1.
  - Response: out_valid at cycles 3 and 4; spin 0 (tie) then 1.
- Saturation:
  - Stimulus: field=−128 with rng=−128, and field=−128 with rng=−127.
  - Response: th=−127, giving spin 1 then spin 0.
  - Stimulus: field=+127 (tanh(7.94)→127) with rng=127, and with rng=126.
  - Response: spin 0, then spin 1.
- Symmetry:
  - Stimulus: field=+16 (x=1.0).
  - Response: th = round(127·0.7616) = 97. field=−16 gives th=−97. Check with rng=96 → spin 1, rng=97 → spin 0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with in_valid continuously high.
  - Response: in_ready=0 from the cycle v3 fills. spin_out is stable. No samples are lost or duplicated; the sequence of 6 spins matches the model after release.
- Window (PBIT_STATS_EN):
  - Stimulus: window_len=4; feed field=+127 with rng=0 ×4, then field=−127 with rng=0 ×4.
  - Response: window_done pulses after the 4th and 8th output transfers; ones_count=4, then 0.
  - Stimulus: window_len=0.
  - Response: a pulse on every transfer.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 for one cycle with 3 samples in flight.
  - Response: out_valid=0 the next cycle and ones_count=0. The first post-reset sample emerges 3 cycles after its input transfer.
